nes_cpu_bus_master: RTL and testbench
=====================================

Name: nes_cpu_bus_master

Overview:
- Console-side initiator for the cartridge CPU bus: the other end of the interface a CoolGirl mapper answers.
- Generates a free-running M2, plus /ROMSEL, R/W, A14..A0 and D7..D0 with NES-like phase timing.
- Runs one read or write bus cycle per accepted request and returns the read byte.
- Used in the dumper/programmer FPGA and as a synthesizable stimulus driver for mapper benches.

Parameters:
- M2_LOW_CYCLES, 4: clk cycles M2 stays low per bus cycle (>=2).
- M2_HIGH_CYCLES, 4: clk cycles M2 stays high per bus cycle (>=2).
- ROMSEL_DELAY, 1: clk cycles after M2 rises before /ROMSEL falls on $8000-$FFFF accesses (0..M2_HIGH_CYCLES-1).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid&req_ready at posedge clk
- req_addr  in  16  full CPU address
- req_rw  in  1  1=read, 0=write
- req_wdata  in  8  write data
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rw  out  1  rw of completed cycle
- rsp_data  out  8  read byte (0 for writes)
- m2  out  1  CPU M2 to cartridge
- romsel  out  1  /ROMSEL, active low
- cpu_rw  out  1  R/W to cartridge
- cpu_addr  out  15  A14..A0
- cpu_data_out  out  8  bus drive value
- cpu_data_oe  out  1  1=master drives data bus
- cpu_data_in  in  8  bus sample value

Behaviour:
- Clock/reset: one clock, clk; reset rst is asynchronous and active-high.
- Reset values: m2=0, romsel=1, cpu_rw=1, cpu_addr=0, cpu_data_out=0, cpu_data_oe=0, req_ready=0, rsp_valid=0, rsp_rw=1, rsp_data=0.
- State machine: LOW, HIGH, with a phase counter of width ceil(log2(max(M2_LOW_CYCLES, M2_HIGH_CYCLES))). A "cur_xfer" flag marks a real transfer; otherwise the cycle is an idle dummy.
- Reset release: first state is LOW with counter 0.
- M2 free-runs at all times, idle or not, so mapper M2 counters keep advancing. M2 is a registered output: 0 in LOW, 1 in HIGH.
- LOW: lasts M2_LOW_CYCLES; romsel=1; cpu_data_oe=0. cpu_addr and cpu_rw are valid from the first LOW cycle (registered at the preceding accept).
- HIGH: lasts M2_HIGH_CYCLES.
  - If the transfer has addr[15]=1, romsel=0 from HIGH cycle index ROMSEL_DELAY to the end of HIGH; otherwise romsel=1.
  - For a write, cpu_data_oe=1 and cpu_data_out=wdata for all of HIGH.
- Falling edge: on the transition HIGH->LOW, romsel=1 and cpu_data_oe=0 in the same cycle M2 falls.
- Handshake:
  - req_ready=1 only during the last HIGH cycle. Accept happens at that posedge.
  - Accept latches addr/rw/wdata. From the next cycle cpu_addr=addr[14:0], cpu_rw=rw, cur_xfer=1.
  - No accept means the next bus cycle is idle: cpu_rw=1, romsel=1, cpu_addr holds its last value, cur_xfer=0.
  - Back-to-back requests give one bus cycle each, with no idle gap. Throughput is one per M2_LOW_CYCLES+M2_HIGH_CYCLES.
- Read sampling: cpu_data_in is sampled at the posedge ending the last HIGH cycle of a read transfer.
- Response:
  - rsp_valid pulses for exactly the first LOW cycle after any transfer, with rsp_rw and rsp_data. rsp_data=0 for writes.
  - Idle cycles produce no response.
  - rsp_data/rsp_rw hold until the next response.
- Latency: accept -> rsp_valid = M2_LOW_CYCLES+M2_HIGH_CYCLES clk.
- A request presented mid-cycle waits, with req_ready low, until the last HIGH cycle. req_valid dropping before acceptance is legal and nothing is issued.
- Reset mid-transfer: all outputs return to reset values immediately. The in-flight request is discarded without rsp_valid, and no partial write is completed.

Test Plan:
- Reset then idle 3 bus cycles: m2 period 8 clk (4 low/4 high); romsel=1, cpu_rw=1, cpu_data_oe=0 throughout; rsp_valid never asserts.
- Read $8123 with cpu_data_in=$A5 during HIGH: cpu_addr=$0123, cpu_rw=1; romsel low from HIGH cycle 1 to M2 fall; rsp_valid one cycle with rsp_data=$A5, rsp_rw=1, exactly 8 clk after accept.
- Write $6000<=$3C: romsel stays 1; cpu_rw=0 through LOW+HIGH; cpu_data_oe=1 with cpu_data_out=$3C only during HIGH; rsp_valid with rsp_rw=0, rsp_data=0.
- Back-to-back: req_valid held for writes $8000<=$01 then read $C000 (bus $77). Expect two consecutive M2 periods with no idle cycle, req_ready pulses exactly twice, and rsp_data=$77 on the second response.
- ROMSEL_DELAY=3, M2_HIGH_CYCLES=4, read $FFFC: romsel low only on HIGH cycle 3 and rises with the M2 fall.
- Assert rst during HIGH of a write to $8000: m2, cpu_data_oe, cpu_rw, romsel go 0/0/1/1 within the same cycle, no rsp_valid; after release the next bus cycle starts in LOW.

Source files
------------

// File: rtl/nes_cpu_bus_master.sv
// nes_cpu_bus_master
//
// Console-side initiator for the cartridge CPU bus. It generates a
// free-running M2 with NES-like phase timing, plus /ROMSEL, R/W, A14..A0
// and D7..D0. Each accepted request becomes one read or write bus cycle,
// and the completed cycle reports back with a single response pulse. When
// no request is pending the bus still cycles as an idle dummy, so the M2
// counters inside the mapper keep advancing.
//
// Ports:
//   clk, rst       system clock; asynchronous active-high reset
//   req_valid      request present
//   req_ready      high only in the last M2-high clock; accept on valid&ready
//   req_addr       full 16-bit CPU address
//   req_rw         1 = read, 0 = write
//   req_wdata      write data
//   rsp_valid      one-clock pulse in the first LOW clock after a transfer
//   rsp_rw         rw of the completed transfer (holds until next response)
//   rsp_data       read byte, 0 for writes (holds until next response)
//   m2             CPU M2 to the cartridge
//   romsel         /ROMSEL, active low
//   cpu_rw         R/W to the cartridge
//   cpu_addr       A14..A0
//   cpu_data_out   value driven onto the data bus
//   cpu_data_oe    1 = master drives the data bus
//   cpu_data_in    value sampled from the data bus
module nes_cpu_bus_master #(
  parameter int M2_LOW_CYCLES  = 4,
  parameter int M2_HIGH_CYCLES = 4,
  parameter int ROMSEL_DELAY   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [15:0] req_addr,
  input  logic        req_rw,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic        rsp_rw,
  output logic [7:0]  rsp_data,
  output logic        m2,
  output logic        romsel,
  output logic        cpu_rw,
  output logic [14:0] cpu_addr,
  output logic [7:0]  cpu_data_out,
  output logic        cpu_data_oe,
  input  logic [7:0]  cpu_data_in
);

  localparam int MAX_CYCLES = (M2_LOW_CYCLES > M2_HIGH_CYCLES) ? M2_LOW_CYCLES : M2_HIGH_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES);

  localparam logic [CW-1:0] LOW_LAST  = CW'(M2_LOW_CYCLES - 1);
  localparam logic [CW-1:0] HIGH_LAST = CW'(M2_HIGH_CYCLES - 1);
  localparam logic [CW-1:0] ROMSEL_IX = CW'(ROMSEL_DELAY);

  typedef enum logic {
    LOW  = 1'b0,
    HIGH = 1'b1
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;

  logic          last_high;
  logic          accept;

  // Attributes of the transfer occupying the current bus cycle.
  // cpu_rw doubles as the transfer direction: it is forced to 1 on idle cycles.
  logic          cur_xfer;
  logic          cur_a15;
  logic [7:0]    cur_wdata;

  // Phase sequencer: LOW for M2_LOW_CYCLES clocks, then HIGH for
  // M2_HIGH_CYCLES clocks, forever, regardless of request traffic.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CW'(1);
    case (state)
      LOW: begin
        if (cnt == LOW_LAST) begin
          state_nxt = HIGH;
          cnt_nxt   = '0;
        end
      end
      HIGH: begin
        if (cnt == HIGH_LAST) begin
          state_nxt = LOW;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = LOW;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= LOW;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // The posedge that ends the last HIGH clock is both the M2 falling edge
  // and the only point where a new request can be taken.
  assign last_high = (state == HIGH) && (cnt == HIGH_LAST);
  assign req_ready = last_high;
  assign accept    = req_valid && last_high;

  // Transfer latch and response generation. At the end of each bus cycle
  // the finished transfer (if any) is reported, the read byte is sampled,
  // and the next cycle is loaded with either the accepted request or an
  // idle dummy. An idle cycle leaves the address lines where they were.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_xfer  <= 1'b0;
      cur_a15   <= 1'b0;
      cur_wdata <= 8'h00;
      cpu_addr  <= 15'h0000;
      cpu_rw    <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rw    <= 1'b1;
      rsp_data  <= 8'h00;
    end else begin
      rsp_valid <= last_high && cur_xfer;
      if (last_high) begin
        if (cur_xfer) begin
          rsp_rw   <= cpu_rw;
          rsp_data <= cpu_rw ? cpu_data_in : 8'h00;
        end
        cur_xfer <= accept;
        if (accept) begin
          cpu_addr  <= req_addr[14:0];
          cur_a15   <= req_addr[15];
          cur_wdata <= req_wdata;
          cpu_rw    <= req_rw;
        end else begin
          cpu_rw    <= 1'b1;
        end
      end
    end
  end

  // Bus strobes are decoded straight from registered state, so they switch
  // cleanly on clock edges and /ROMSEL and the data drive release in the
  // same clock that M2 falls.
  assign m2           = (state == HIGH);
  assign romsel       = ~((state == HIGH) && cur_xfer && cur_a15 && (cnt >= ROMSEL_IX));
  assign cpu_data_oe  = (state == HIGH) && cur_xfer && !cpu_rw;
  assign cpu_data_out = cpu_data_oe ? cur_wdata : 8'h00;

endmodule

// File: tb/tb_nes_cpu_bus_master.sv
// Testbench for nes_cpu_bus_master.
// A second instance with ROMSEL_DELAY=3 shares all inputs so the late
// /ROMSEL timing is checked on the same traffic. The reference model tracks
// the position inside the 8-clock M2 period and the transfer that owns the
// current period, and derives every expected pin from those.
module tb_nes_cpu_bus_master;

  localparam int LOWC  = 4;
  localparam int HIGHC = 4;
  localparam int PER   = LOWC + HIGHC;
  localparam int RD1   = 1;
  localparam int RD3   = 3;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic [15:0] req_addr;
  logic        req_rw;
  logic [7:0]  req_wdata;
  logic [7:0]  cpu_data_in;

  logic        req_ready, rsp_valid, rsp_rw, m2, romsel, cpu_rw, cpu_data_oe;
  logic [7:0]  rsp_data, cpu_data_out;
  logic [14:0] cpu_addr;

  logic        req_ready2, rsp_valid2, rsp_rw2, m2b, romsel2, cpu_rw2, cpu_data_oe2;
  logic [7:0]  rsp_data2, cpu_data_out2;
  logic [14:0] cpu_addr2;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int          mPos;
  logic        mCurValid;
  logic [15:0] mCurAddr;
  logic        mCurRw;
  logic [7:0]  mCurWdata;
  logic [14:0] mLastAddr;
  logic        mRspPend;
  logic        mRspRw;
  logic [7:0]  mRspData;
  int          readyCount;

  nes_cpu_bus_master #(.M2_LOW_CYCLES(LOWC), .M2_HIGH_CYCLES(HIGHC), .ROMSEL_DELAY(RD1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_rw(req_rw), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rw(rsp_rw), .rsp_data(rsp_data),
    .m2(m2), .romsel(romsel), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr),
    .cpu_data_out(cpu_data_out), .cpu_data_oe(cpu_data_oe), .cpu_data_in(cpu_data_in)
  );

  nes_cpu_bus_master #(.M2_LOW_CYCLES(LOWC), .M2_HIGH_CYCLES(HIGHC), .ROMSEL_DELAY(RD3)) dut3 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready2),
    .req_addr(req_addr), .req_rw(req_rw), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid2), .rsp_rw(rsp_rw2), .rsp_data(rsp_data2),
    .m2(m2b), .romsel(romsel2), .cpu_rw(cpu_rw2), .cpu_addr(cpu_addr2),
    .cpu_data_out(cpu_data_out2), .cpu_data_oe(cpu_data_oe2), .cpu_data_in(cpu_data_in)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One comparison: count it, and report tag/observed/expected on failure.
  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [15:0] a, input logic rw,
                               input logic [7:0] wd, input logic [7:0] din);
    req_valid   = v;
    req_addr    = a;
    req_rw      = rw;
    req_wdata   = wd;
    cpu_data_in = din;
  endtask

  task automatic modelReset();
    mPos      = 0;
    mCurValid = 1'b0;
    mCurAddr  = 16'h0000;
    mCurRw    = 1'b1;
    mCurWdata = 8'h00;
    mLastAddr = 15'h0000;
    mRspPend  = 1'b0;
    mRspRw    = 1'b1;
    mRspData  = 8'h00;
  endtask

  // Compare every pin of the main instance, plus /ROMSEL and M2 of the
  // late-ROMSEL instance, with what the period position implies.
  task automatic checkAll();
    logic inHigh;
    logic expOe;
    inHigh = (mPos >= LOWC);
    expOe  = mCurValid && !mCurRw && inHigh;
    checkOutput("m2", {15'd0, m2}, {15'd0, inHigh});
    checkOutput("m2_rd3", {15'd0, m2b}, {15'd0, inHigh});
    checkOutput("req_ready", {15'd0, req_ready}, {15'd0, (mPos == PER - 1)});
    checkOutput("rsp_valid", {15'd0, rsp_valid}, {15'd0, mRspPend});
    checkOutput("rsp_rw", {15'd0, rsp_rw}, {15'd0, mRspRw});
    checkOutput("rsp_data", {8'd0, rsp_data}, {8'd0, mRspData});
    checkOutput("cpu_rw", {15'd0, cpu_rw}, {15'd0, (mCurValid ? mCurRw : 1'b1)});
    checkOutput("cpu_addr", {1'b0, cpu_addr}, {1'b0, mLastAddr});
    checkOutput("romsel", {15'd0, romsel},
                {15'd0, !(mCurValid && mCurAddr[15] && mPos >= LOWC + RD1)});
    checkOutput("romsel_rd3", {15'd0, romsel2},
                {15'd0, !(mCurValid && mCurAddr[15] && mPos >= LOWC + RD3)});
    checkOutput("cpu_data_oe", {15'd0, cpu_data_oe}, {15'd0, expOe});
    if (expOe)
      checkOutput("cpu_data_out", {8'd0, cpu_data_out}, {8'd0, mCurWdata});
  endtask

  // Check at the negedge, advance one clock, update the model with the
  // inputs that were present at the posedge, and return at the next negedge.
  task automatic runCycle();
    checkAll();
    if (req_ready === 1'b1) readyCount++;
    @(posedge clk);
    if (mPos == PER - 1) begin
      mRspPend = mCurValid;
      if (mCurValid) begin
        mRspRw   = mCurRw;
        mRspData = mCurRw ? cpu_data_in : 8'h00;
      end
      mCurValid = req_valid;
      if (req_valid) begin
        mCurAddr  = req_addr;
        mCurRw    = req_rw;
        mCurWdata = req_wdata;
        mLastAddr = req_addr[14:0];
      end
    end else begin
      mRspPend = 1'b0;
    end
    mPos = (mPos + 1) % PER;
    @(negedge clk);
  endtask

  // Present a request and run until it is taken; a bounded wait.
  task automatic waitAccept(input string tag);
    logic acc;
    acc = 1'b0;
    for (int i = 0; i < 3 * PER && !acc; i++) begin
      acc = (req_ready === 1'b1);
      runCycle();
    end
    checkOutput(tag, {15'd0, acc}, 16'd1);
  endtask

  initial begin
    rst = 1'b1;
    readyCount = 0;
    applyStimulus(1'b0, 16'h0000, 1'b1, 8'h00, 8'h00);
    modelReset();
    #3;
    checkOutput("rst_m2", {15'd0, m2}, 16'd0);
    checkOutput("rst_romsel", {15'd0, romsel}, 16'd1);
    checkOutput("rst_cpu_rw", {15'd0, cpu_rw}, 16'd1);
    checkOutput("rst_cpu_addr", {1'b0, cpu_addr}, 16'd0);
    checkOutput("rst_data_out", {8'd0, cpu_data_out}, 16'd0);
    checkOutput("rst_data_oe", {15'd0, cpu_data_oe}, 16'd0);
    checkOutput("rst_req_ready", {15'd0, req_ready}, 16'd0);
    checkOutput("rst_rsp_valid", {15'd0, rsp_valid}, 16'd0);
    checkOutput("rst_rsp_rw", {15'd0, rsp_rw}, 16'd1);
    checkOutput("rst_rsp_data", {8'd0, rsp_data}, 16'd0);
    @(negedge clk);
    rst = 1'b0;

    // Three idle bus cycles
    for (int i = 0; i < 3 * PER; i++) runCycle();

    // Read $8123 returning $A5
    applyStimulus(1'b1, 16'h8123, 1'b1, 8'h00, 8'hA5);
    waitAccept("accept_read");
    applyStimulus(1'b0, 16'h0000, 1'b1, 8'h00, 8'hA5);
    for (int i = 0; i < PER + 2; i++) runCycle();
    checkOutput("read_rsp_data", {8'd0, rsp_data}, 16'h00A5);

    // Write $6000 <= $3C
    applyStimulus(1'b1, 16'h6000, 1'b0, 8'h3C, 8'h00);
    waitAccept("accept_write");
    applyStimulus(1'b0, 16'h0000, 1'b1, 8'h00, 8'h00);
    for (int i = 0; i < PER + 2; i++) runCycle();
    checkOutput("write_rsp_rw", {15'd0, rsp_rw}, 16'd0);

    // Back-to-back: write $8000 <= $01 then read $C000 returning $77
    readyCount = 0;
    applyStimulus(1'b1, 16'h8000, 1'b0, 8'h01, 8'h77);
    waitAccept("accept_b2b_1");
    applyStimulus(1'b1, 16'hC000, 1'b1, 8'h00, 8'h77);
    waitAccept("accept_b2b_2");
    checkOutput("b2b_ready_pulses", readyCount[15:0], 16'd2);
    applyStimulus(1'b0, 16'h0000, 1'b1, 8'h00, 8'h77);
    for (int i = 0; i < PER + 2; i++) runCycle();
    checkOutput("b2b_rsp_data", {8'd0, rsp_data}, 16'h0077);

    // Read $FFFC for the late /ROMSEL instance
    applyStimulus(1'b1, 16'hFFFC, 1'b1, 8'h00, 8'h5A);
    waitAccept("accept_fffc");
    applyStimulus(1'b0, 16'h0000, 1'b1, 8'h00, 8'h5A);
    for (int i = 0; i < PER + 2; i++) runCycle();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 2) != 0), 16'($urandom), 1'($urandom),
                    8'($urandom), 8'($urandom));
      runCycle();
    end

    // Reset during HIGH of a write to $8000
    applyStimulus(1'b1, 16'h8000, 1'b0, 8'hE7, 8'h00);
    waitAccept("accept_rstwrite");
    applyStimulus(1'b0, 16'h0000, 1'b1, 8'h00, 8'h00);
    while (mPos != LOWC + 1) runCycle();
    checkOutput("pre_rst_oe", {15'd0, cpu_data_oe}, 16'd1);
    rst = 1'b1;
    #1;
    checkOutput("midrst_m2", {15'd0, m2}, 16'd0);
    checkOutput("midrst_oe", {15'd0, cpu_data_oe}, 16'd0);
    checkOutput("midrst_cpu_rw", {15'd0, cpu_rw}, 16'd1);
    checkOutput("midrst_romsel", {15'd0, romsel}, 16'd1);
    checkOutput("midrst_rsp_valid", {15'd0, rsp_valid}, 16'd0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("midrst_hold_m2", {15'd0, m2}, 16'd0);
    rst = 1'b0;
    modelReset();
    for (int i = 0; i < 2 * PER; i++) runCycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
